// File: rtl/i2s_audio_tx_if.sv
// rtl/i2s_audio_tx_if.sv - audio sample, control and serial line bundle for the DAC transmitter
interface i2s_audio_tx_if #(
    parameter int IN_W = 18
);
    logic            ntscmode;
    logic            mono;
    logic [1:0]      volume;
    logic [IN_W-1:0] audio_l;
    logic [IN_W-1:0] audio_r;
    logic            sample_req;
    logic            hp_bck;
    logic            hp_ws;
    logic            hp_din;

    modport master (
        output ntscmode, mono, volume, audio_l, audio_r,
        input  sample_req, hp_bck, hp_ws, hp_din
    );

    modport slave (
        input  ntscmode, mono, volume, audio_l, audio_r,
        output sample_req, hp_bck, hp_ws, hp_din
    );
endinterface

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - I2S / left-justified stereo DAC transmitter with bck divider and 3-stage sample pipeline
module i2s_audio_tx #(
    parameter int IN_W        = 18,
    parameter int SAMPLE_W    = 16,
    parameter int FS          = 24000,
    parameter int CLK_HZ_PAL  = 31500000,
    parameter int CLK_HZ_NTSC = 32940000,
    parameter int FORMAT      = 1,
    parameter int OUT_SHIFT   = 2
) (
    input  logic          clk,
    input  logic          pll_lock,
    i2s_audio_tx_if.slave bus
);
    localparam int DIV_PAL  = CLK_HZ_PAL / (FS * 2 * SAMPLE_W) / 2;
    localparam int DIV_NTSC = CLK_HZ_NTSC / (FS * 2 * SAMPLE_W) / 2;
    localparam int DIV_MAX  = (DIV_NTSC > DIV_PAL) ? DIV_NTSC : DIV_PAL;
    localparam int CNT_W    = $clog2(DIV_MAX) + 1;
    localparam int FRAME    = 2 * SAMPLE_W;
    localparam int BIT_W    = $clog2(FRAME);
    localparam int S1_SH    = IN_W - SAMPLE_W - 1;

    function automatic logic signed [SAMPLE_W-1:0] sat_in(input logic [IN_W-1:0] x);
        logic signed [SAMPLE_W:0] t;
        t = (SAMPLE_W+1)'($signed(x) >>> S1_SH);
        if (t[SAMPLE_W] != t[SAMPLE_W-1])
            return t[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        return t[SAMPLE_W-1:0];
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] vol_scale(input logic signed [SAMPLE_W-1:0] x,
                                                             input logic [1:0] v);
        case (v)
            2'd0:    return '0;
            2'd1:    return x >>> 2;
            2'd2:    return x >>> 1;
            default: return x;
        endcase
    endfunction

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_lim;
    logic             bck_q;
    logic             tick;
    logic             fall;

    // ">=" keeps a mid-count switch to the shorter divider from running past the new limit
    assign div_lim = bus.ntscmode ? CNT_W'(DIV_NTSC - 1) : CNT_W'(DIV_PAL - 1);
    assign tick    = (div_cnt >= div_lim);
    assign fall    = tick & bck_q;

    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            div_cnt <= '0;
            bck_q   <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            bck_q   <= ~bck_q;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    logic signed [SAMPLE_W-1:0] s1_l, s1_r, s2_l, s2_r, s3_l, s3_r;
    logic signed [SAMPLE_W-1:0] mono_mix;

    assign mono_mix = (s2_l >>> 1) + (s2_r >>> 1);

    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            s1_l <= '0;
            s1_r <= '0;
            s2_l <= '0;
            s2_r <= '0;
            s3_l <= '0;
            s3_r <= '0;
        end else begin
            s1_l <= sat_in(bus.audio_l);
            s1_r <= sat_in(bus.audio_r);
            s2_l <= vol_scale(s1_l, bus.volume);
            s2_r <= vol_scale(s1_r, bus.volume);
            s3_l <= (bus.mono ? mono_mix : s2_l) >>> OUT_SHIFT;
            s3_r <= (bus.mono ? mono_mix : s2_r) >>> OUT_SHIFT;
        end
    end

    logic [BIT_W-1:0] bitcnt;
    logic [BIT_W-1:0] bitcnt_nxt;
    logic [FRAME-1:0] tx;
    logic [FRAME-1:0] tx_nxt;
    logic [FRAME-1:0] tx_sh;
    logic             wrap;
    logic             lj_q;
    logic             i2s_q;
    logic             req_q;

    assign wrap       = (bitcnt == BIT_W'(FRAME - 1));
    assign bitcnt_nxt = wrap ? '0 : bitcnt + 1'b1;
    assign tx_nxt     = wrap ? {s3_l, s3_r} : tx;
    assign tx_sh      = tx_nxt << bitcnt_nxt;

    // Everything serial moves on bck falling edges; i2s_q lags lj_q by one bit for Philips framing
    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            bitcnt <= '0;
            tx     <= '0;
            lj_q   <= 1'b0;
            i2s_q  <= 1'b0;
            req_q  <= 1'b0;
        end else begin
            req_q <= fall & wrap;
            if (fall) begin
                bitcnt <= bitcnt_nxt;
                tx     <= tx_nxt;
                lj_q   <= tx_sh[FRAME-1];
                i2s_q  <= lj_q;
            end
        end
    end

    assign bus.hp_bck     = bck_q;
    assign bus.hp_ws      = bitcnt[BIT_W-1];
    assign bus.hp_din     = (FORMAT != 0) ? i2s_q : lj_q;
    assign bus.sample_req = req_q;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - directed bench: left-justified and I2S instances driven from shared inputs
module tb_i2s_audio_tx;
    localparam int BCK_A = 0, WS_A = 1, REQ_A = 2, REQ_B = 3, BCK_B = 4, WS_B = 5, DIN_A = 6, DIN_B = 7;

    logic        clk = 1'b0;
    logic        pll_lock;
    logic        ntscmode;
    logic        mono;
    logic [1:0]  volume;
    logic [17:0] audio_l;
    logic [17:0] audio_r;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    i2s_audio_tx_if #(.IN_W(18)) if_a ();
    i2s_audio_tx_if #(.IN_W(18)) if_b ();

    assign if_a.ntscmode = ntscmode;
    assign if_a.mono     = mono;
    assign if_a.volume   = volume;
    assign if_a.audio_l  = audio_l;
    assign if_a.audio_r  = audio_r;
    assign if_b.ntscmode = ntscmode;
    assign if_b.mono     = mono;
    assign if_b.volume   = volume;
    assign if_b.audio_l  = audio_l;
    assign if_b.audio_r  = audio_r;

    i2s_audio_tx #(.FORMAT(0), .OUT_SHIFT(0)) u_lj (
        .clk      (clk),
        .pll_lock (pll_lock),
        .bus      (if_a)
    );

    i2s_audio_tx #(.FORMAT(1), .OUT_SHIFT(0)) u_i2s (
        .clk      (clk),
        .pll_lock (pll_lock),
        .bus      (if_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic get(input int sel);
        case (sel)
            BCK_A:   return if_a.hp_bck;
            WS_A:    return if_a.hp_ws;
            REQ_A:   return if_a.sample_req;
            REQ_B:   return if_b.sample_req;
            BCK_B:   return if_b.hp_bck;
            WS_B:    return if_b.hp_ws;
            DIN_A:   return if_a.hp_din;
            DIN_B:   return if_b.hp_din;
            default: return 1'b0;
        endcase
    endfunction

    // Returns the number of clocks until the selected signal moves to lvl, or -1 on timeout
    task automatic wait_edge(input int sel, input logic lvl, input int budget, output int n);
        logic prev;
        prev = get(sel);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (get(sel) === lvl && prev !== lvl) begin
                n = i;
                break;
            end
            prev = get(sel);
        end
    endtask

    // Waits for a frame latch, then records din and ws at each following bck rising edge
    task automatic grab(input int inst, input int nbits, output logic [63:0] d, output logic [63:0] w);
        int   n;
        int   k;
        logic prev;
        logic cur;
        d = '0;
        w = '0;
        k = 0;
        wait_edge(inst ? REQ_B : REQ_A, 1'b1, 3000, n);
        prev = get(inst ? BCK_B : BCK_A);
        for (int i = 0; i < 3000 && k < nbits; i++) begin
            @(negedge clk);
            cur = get(inst ? BCK_B : BCK_A);
            if (cur && !prev) begin
                d = {d[62:0], get(inst ? DIN_B : DIN_A)};
                w = {w[62:0], get(inst ? WS_B : WS_A)};
                k++;
            end
            prev = cur;
        end
    endtask

    initial begin
        int          n;
        int          mx;
        int          run;
        int          falls;
        logic        prev;
        logic        cur;
        logic        bad;
        logic [63:0] d;
        logic [63:0] w;

        pll_lock = 1'b0;
        ntscmode = 1'b0;
        mono     = 1'b0;
        volume   = 2'd3;
        audio_l  = '0;
        audio_r  = '0;
        bad      = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if ({if_a.hp_bck, if_a.hp_ws, if_a.hp_din, if_a.sample_req,
                 if_b.hp_bck, if_b.hp_ws, if_b.hp_din, if_b.sample_req} !== 8'h00)
                bad = 1'b1;
        end
        check("reset_outputs_zero", 64'(bad), 64'd0);

        pll_lock = 1'b1;
        wait_edge(BCK_A, 1'b1, 200, n);
        check("first_bck_rise", 64'(n), 64'd20);
        wait_edge(BCK_A, 1'b1, 200, n);
        check("bck_period_pal", 64'(n), 64'd40);
        wait_edge(WS_A, 1'b1, 3000, n);
        wait_edge(WS_A, 1'b1, 3000, n);
        check("ws_period_pal", 64'(n), 64'd1280);
        wait_edge(REQ_A, 1'b1, 3000, n);
        wait_edge(REQ_A, 1'b1, 3000, n);
        check("req_period_pal", 64'(n), 64'd1280);
        @(negedge clk);
        check("req_one_clk", 64'(if_a.sample_req), 64'd0);

        ntscmode = 1'b1;
        wait_edge(BCK_A, 1'b1, 200, n);
        wait_edge(BCK_A, 1'b0, 200, n);
        check("ntsc_half_high", 64'(n), 64'd21);
        wait_edge(BCK_A, 1'b1, 200, n);
        check("ntsc_half_low", 64'(n), 64'd21);
        wait_edge(REQ_A, 1'b1, 3000, n);
        wait_edge(REQ_A, 1'b1, 3000, n);
        check("req_period_ntsc", 64'(n), 64'd1344);

        mx   = 0;
        run  = 0;
        prev = if_a.hp_bck;
        for (int i = 0; i < 1500; i++) begin
            if (i % 7 == 0) ntscmode = ~ntscmode;
            @(negedge clk);
            cur = if_a.hp_bck;
            if (cur !== prev) begin
                if (run > mx) mx = run;
                run = 1;
            end else begin
                run++;
            end
            prev = cur;
        end
        check("ntsc_toggle_half_in_20_21", 64'(mx >= 20 && mx <= 21), 64'd1);
        ntscmode = 1'b0;

        audio_l = 18'h04000;
        audio_r = 18'h3C000;
        wait_edge(REQ_A, 1'b1, 3000, n);
        grab(0, 32, d, w);
        check("lj_stereo_data", d, 64'h2000E000);
        check("lj_stereo_ws", w, 64'h0000FFFF);

        audio_l = 18'h1FFFF;
        audio_r = 18'h20000;
        wait_edge(REQ_A, 1'b1, 3000, n);
        grab(0, 32, d, w);
        check("lj_saturate", d, 64'h7FFF8000);

        volume = 2'd1;
        wait_edge(REQ_A, 1'b1, 3000, n);
        grab(0, 32, d, w);
        check("lj_volume1", d, 64'h1FFFE000);

        volume  = 2'd3;
        mono    = 1'b1;
        audio_l = 18'h3FFFE;
        audio_r = 18'h00000;
        wait_edge(REQ_B, 1'b1, 3000, n);
        wait_edge(REQ_B, 1'b1, 3000, n);
        audio_l = 18'h04000;
        grab(1, 33, d, w);
        check("i2s_prev_right_lsb", 64'(d[32]), 64'd1);
        check("i2s_mono_data", 64'(d[31:0]), 64'h10001000);
        check("i2s_ws", 64'(w[32:0]), 64'h1FFFE);

        mono    = 1'b0;
        audio_l = 18'h1FFFF;
        audio_r = 18'h20000;
        wait_edge(REQ_A, 1'b1, 3000, n);
        wait_edge(REQ_A, 1'b1, 3000, n);
        for (int j = 0; j < 9; j++) wait_edge(BCK_A, 1'b0, 200, n);
        wait_edge(BCK_A, 1'b1, 200, n);
        check("pre_reset_bck_ws_din", 64'({if_a.hp_bck, if_a.hp_ws, if_a.hp_din}), 64'b101);
        #2;
        pll_lock = 1'b0;
        #1;
        check("async_reset_zero",
              64'({if_a.hp_bck, if_a.hp_ws, if_a.hp_din, if_a.sample_req,
                   if_b.hp_bck, if_b.hp_ws, if_b.hp_din, if_b.sample_req}), 64'd0);
        repeat (3) @(negedge clk);
        pll_lock = 1'b1;
        falls = 0;
        bad   = 1'b0;
        prev  = if_a.hp_bck;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cur = if_a.hp_bck;
            if (prev && !cur) falls++;
            if (if_a.sample_req) break;
            if (if_a.hp_din !== 1'b0) bad = 1'b1;
            prev = cur;
        end
        check("falls_to_first_req", 64'(falls), 64'd32);
        check("din_zero_before_latch", 64'(bad), 64'd0);

        volume = 2'd0;
        wait_edge(REQ_A, 1'b1, 3000, n);
        grab(0, 32, d, w);
        check("volume0_mute", d, 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
- Parametrised I2S/left-justified serial audio transmitter for the headphone/PA DAC path, fed by the core's signed stereo audio.
- Runs entirely in the `clk` domain. The bit clock is a registered divider output, never used as a clock internally.
- Adds over the previous generation:
  - configurable word width;
  - Philips-I2S or left-justified framing;
  - true stereo or mono-mix;
  - a per-frame sample request strobe.

Parameters:
- IN_W, 18, width of signed input samples.
- SAMPLE_W, 16, bits per channel slot; frame = 2*SAMPLE_W bck cycles.
- FS, 24000, target sample rate in Hz.
- CLK_HZ_PAL, 31500000, clk frequency when ntscmode=0.
- CLK_HZ_NTSC, 32940000, clk frequency when ntscmode=1.
- FORMAT, 1, 0 = left-justified, 1 = Philips I2S (data one bck after ws edge).
- OUT_SHIFT, 2, final arithmetic right shift (amp headroom).

Ports:
- clk  in  1  system clock.
- pll_lock  in  1  reset, asynchronous, active-low (low = reset).
- ntscmode  in  1  selects divider constant.
- mono  in  1  1 = both slots carry (L+R)/2.
- volume  in  2  0 mute, 1 = >>2, 2 = >>1, 3 = unity.
- audio_l  in  IN_W  signed left sample, sampled every clk.
- audio_r  in  IN_W  signed right sample.
- sample_req  out  1  one-clk pulse when a frame's samples are latched.
- hp_bck  out  1  serial bit clock.
- hp_ws  out  1  word select, 0 = left slot.
- hp_din  out  1  serial data, MSB first.

Behaviour:

Reset (pll_lock low, asynchronous):
- Divider counter, bck register, bit counter, shift/tx registers, pipeline registers, and delay flop all clear to 0.
- hp_bck=0, hp_ws=0, hp_din=0, sample_req=0.
- Outputs stay 0 while pll_lock is low.
- On release, the first bck toggle occurs DIV clks later.

Divider:
- DIV = CLK_HZ/(FS*2*SAMPLE_W)/2, integer truncation. Defaults give PAL=20, NTSC=21.
- Counter counts 0..DIV-1. At DIV-1 it resets to 0 and hp_bck toggles.
- Comparison is "counter >= DIV-1", so switching ntscmode mid-count never overruns.

Bit clock edges:
- All serial state changes on hp_bck falling edges (the toggle 1->0), so the DAC samples on rising edges.
- Bit counter is log2(2*SAMPLE_W) bits wide, +1 per falling edge, wraps 2*SAMPLE_W-1 -> 0.

Processing pipeline (3 clk, free-running):
- **Stage 1:** arithmetic shift by IN_W-SAMPLE_W-1 into SAMPLE_W+1 bits, then saturate to SAMPLE_W: max 0x7FF..F, min 0x800..0.
- **Stage 2:** volume scaling with sign-extending shifts.
- **Stage 3:** if mono, L=R=(L>>>1)+(R>>>1); else channels unchanged. Then arithmetic >>>OUT_SHIFT.

Frame latch:
- On the falling edge where the bit counter wraps to 0, both stage-3 values are loaded into a 2*SAMPLE_W tx register {L,R}.
- sample_req pulses high for exactly that clk.
- Volume, mono, and input changes affect the line only at the next latch; no mid-frame tearing.

Serial output:
- hp_ws = bit counter MSB.
- Left-justified (FORMAT=0): hp_din = tx bit [2*SAMPLE_W-1 - bitcnt], updated on the falling edge.
- I2S (FORMAT=1): hp_din is the left-justified data bit delayed by one bck falling edge. Consequences:
  - the MSB appears one bck after each ws transition;
  - the previous frame's right-channel LSB is emitted during bitcnt 0.

Reset mid-frame: frame is aborted; after release, the first latch occurs at the first wrap (after 2*SAMPLE_W falling edges) with tx=0 output until then.

Test Plan:
- **Reset/startup:** pll_lock low 100 clks then high, defaults, ntscmode=0 -> all outputs 0 during reset; first hp_bck rise 20 clks after release; hp_bck period 40 clks; hp_ws period 1280 clks; sample_req every 1280 clks.
- **NTSC divider:** ntscmode=1 -> hp_bck half-period 21 clks, frame 1344 clks. Toggling ntscmode mid-count -> no half-period exceeds 21 clks.
- **Stereo data, FORMAT=0, OUT_SHIFT=0, volume=3:** audio_l=18'h04000, audio_r=18'h3C000 -> left slot 0x2000, right slot 0xE000, MSB aligned with ws edge.
- **Saturation:** audio_l=18'h1FFFF, audio_r=18'h20000 -> slots 0x7FFF and 0x8000. With volume=1 (still OUT_SHIFT=0) -> 0x1FFF and 0xE000.
- **Mono + I2S framing, FORMAT=1:** mono=1, L=18'h04000, R=0 -> both slots 0x1000. hp_din MSB one bck after each hp_ws edge; the LSB of the right slot appears in bitcnt 0 of the next frame.
- **Async reset mid-frame:** pulse pll_lock low for 3 clks at bitcnt 9 -> outputs 0 immediately (same clk). Next sample_req occurs 32 falling edges after restart; volume=0 at any time yields all-zero slots from the next frame.
